// File: rtl/input_buffer.sv
// input_buffer: memory-mapped input peripheral in the 0x78xx page.
// Synchronises board switches and push-buttons, debounces the buttons,
// latches button presses in sticky write-1-to-clear flags and serves
// byte/half/word loads from the LSU. The load path is purely combinational.
module input_buffer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_BTN         = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [15:0]        i_in_buf_addr,
    input  logic [31:0]        i_in_buf_data,
    input  logic               i_lsu_wren,
    input  logic [2:0]         i_control,
    input  logic [31:0]        i_io_sw,
    input  logic [NUM_BTN-1:0] i_io_btn,
    output logic [31:0]        o_in_buf_data
);

    // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit for tiny values.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // func3 encodings of the loads and stores this block understands.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    // Word indices (offset[7:2]) of the mapped registers.
    localparam logic [5:0] WORD_SW   = 6'h00;
    localparam logic [5:0] WORD_LVL  = 6'h04;
    localparam logic [5:0] WORD_EDGE = 6'h05;

    logic               sel;
    logic [7:0]         offset;

    logic [31:0]        sw_meta;
    logic [31:0]        sw_sync;
    logic [NUM_BTN-1:0] btn_meta;       // raw, active-low
    logic [NUM_BTN-1:0] btn_sync;       // raw, active-low
    logic [NUM_BTN-1:0] btn_pressed;    // synced, active-high

    logic [CNT_W-1:0]   db_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] btn_level;      // debounced pressed state
    logic [NUM_BTN-1:0] btn_level_q;    // previous debounced state, for rise detect
    logic [NUM_BTN-1:0] btn_edge;       // sticky press flags

    logic               clr_lane0;
    logic [NUM_BTN-1:0] clr_mask;

    logic [31:0]        reg_word;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Store data above the flag bits has no destination.
    logic unused_store_bits;
    assign unused_store_bits = ^i_in_buf_data[31:NUM_BTN];

    assign sel         = (i_in_buf_addr[15:8] == 8'h78);
    assign offset      = i_in_buf_addr[7:0];
    assign btn_pressed = ~btn_sync;

    // Two-flop synchronisers; button stages reset to the released (high) level.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and the chain behaves as a true pipeline.
        if (!i_rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '1;
            btn_sync <= '1;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_sync <= btn_meta;
        end
    end

    // Per-button debounce: the synced level must differ for DEBOUNCE_CYCLES
    // consecutive cycles before the debounced state follows it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btn_level <= '0;
            // NOTE: the counter array is explicitly reset; it is a handful of
            // flops, not a RAM, and a stale count would shorten the first debounce.
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_pressed[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    btn_level[i] <= btn_pressed[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Work out which flag bits a store is clearing this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        clr_lane0 = 1'b0;
        clr_mask  = '0;
        // Byte lane 0 (offset 0x14) is written only if the access covers it.
        case (i_control[1:0])
            2'b00:   clr_lane0 = (offset[1:0] == 2'b00);
            2'b01:   clr_lane0 = ~offset[1];
            2'b10:   clr_lane0 = 1'b1;
            default: clr_lane0 = 1'b0;
        endcase
        if (sel && i_lsu_wren && (offset[7:2] == WORD_EDGE) && clr_lane0) begin
            clr_mask = i_in_buf_data[NUM_BTN-1:0];
        end
    end

    // Sticky press flags: set on a debounced rise, cleared by write-1; set wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btn_level_q <= '0;
            btn_edge    <= '0;
        end else begin
            btn_level_q <= btn_level;
            btn_edge    <= (btn_edge & ~clr_mask) | (btn_level & ~btn_level_q);
        end
    end

    // Load path: pick the addressed word, then the lane, then extend.
    always_comb begin
        reg_word      = '0;
        ld_byte       = '0;
        ld_half       = '0;
        o_in_buf_data = '0;

        case (offset[7:2])
            WORD_SW:   reg_word = sw_sync;
            WORD_LVL:  reg_word = 32'(btn_level);
            WORD_EDGE: reg_word = 32'(btn_edge);
            default:   reg_word = '0;
        endcase

        case (offset[1:0])
            2'b00:   ld_byte = reg_word[7:0];
            2'b01:   ld_byte = reg_word[15:8];
            2'b10:   ld_byte = reg_word[23:16];
            default: ld_byte = reg_word[31:24];
        endcase

        ld_half = offset[1] ? reg_word[31:16] : reg_word[15:0];

        if (sel) begin
            case (i_control)
                F3_LB:   o_in_buf_data = {{24{ld_byte[7]}}, ld_byte};
                F3_LBU:  o_in_buf_data = {24'h0, ld_byte};
                F3_LH:   o_in_buf_data = {{16{ld_half[15]}}, ld_half};
                F3_LHU:  o_in_buf_data = {16'h0, ld_half};
                F3_LW:   o_in_buf_data = reg_word;
                default: o_in_buf_data = '0;
            endcase
        end
    end

endmodule
